// File: rtl/song_recorder.sv
// Records live key input, quantised to beat ticks, into 16-bit song words for the song RAM write port.
// Optional REC_TRIM_LEAD_EN: drop leading silence so the first stored word is the first real note.
module song_recorder #(
   parameter int NOTE_AW = 7,
   parameter int MAX_DUR = 63
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 record,
   input  logic                 beat,
   input  logic [1:0]           song,
   input  logic                 key_valid,
   input  logic [5:0]           key_note,
   output logic                 wr_en,
   output logic [NOTE_AW+1:0]   wr_addr,
   output logic [15:0]          wr_data,
   output logic                 recording,
   output logic                 song_full,
   output logic                 rec_done
);

   localparam logic [NOTE_AW-1:0] LAST_IDX = '1;
   localparam logic [5:0]         DUR_MAX  = 6'(MAX_DUR);
   localparam logic [15:0]        END_WORD = 16'h8000;

   typedef enum logic [1:0] {S_IDLE, S_TRACK, S_COMMIT, S_TERM} state_t;

   state_t             state;
   logic               rec_q;
   logic [1:0]         song_q;
   logic [NOTE_AW-1:0] idx;
   logic [5:0]         seg_note;
   logic [5:0]         dur;

   logic [5:0] cur_in;
   logic       count_en;
   logic [5:0] dur_n;
   logic       note_chg;
   logic       do_commit;

   always_comb begin
      cur_in = key_valid ? key_note : 6'd0;
`ifdef REC_TRIM_LEAD_EN
      count_en = !((idx == '0) && (seg_note == 6'd0));
`else
      count_en = 1'b1;
`endif
      dur_n     = dur + {5'd0, beat & count_en};
      note_chg  = (cur_in != seg_note);
      // zero-length segments are never stored, whatever ends them
      do_commit = (dur_n != 6'd0) && (note_chg || (dur_n == DUR_MAX) || !record);
   end

   // The write of a COMMIT/TERM step is registered on entry so it is on the bus during that step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         rec_q     <= 1'b0;
         song_q    <= 2'd0;
         idx       <= '0;
         seg_note  <= 6'd0;
         dur       <= 6'd0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= 16'd0;
         recording <= 1'b0;
         song_full <= 1'b0;
         rec_done  <= 1'b0;
      end else begin
         rec_q    <= record;
         wr_en    <= 1'b0;
         rec_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (record && !rec_q) begin
                  song_q    <= song;
                  idx       <= '0;
                  seg_note  <= cur_in;
                  dur       <= 6'd0;
                  song_full <= 1'b0;
                  recording <= 1'b1;
                  state     <= S_TRACK;
               end
            end
            S_TRACK: begin
               if (do_commit) begin
                  wr_en   <= 1'b1;
                  wr_addr <= {song_q, idx};
                  wr_data <= {1'b0, seg_note, dur_n, 3'b000};
                  idx     <= idx + NOTE_AW'(1);
                  dur     <= 6'd0;
                  state   <= S_COMMIT;
               end else if (!record) begin
                  wr_en    <= 1'b1;
                  wr_addr  <= {song_q, idx};
                  wr_data  <= END_WORD;
                  rec_done <= 1'b1;
                  state    <= S_TERM;
               end else begin
                  dur <= dur_n;
                  if (note_chg) seg_note <= cur_in;
               end
            end
            S_COMMIT: begin
               seg_note <= cur_in;
               dur      <= 6'd0;
               if ((idx == LAST_IDX) || !record) begin
                  if (idx == LAST_IDX) song_full <= 1'b1;
                  wr_en    <= 1'b1;
                  wr_addr  <= {song_q, idx};
                  wr_data  <= END_WORD;
                  rec_done <= 1'b1;
                  state    <= S_TERM;
               end else begin
                  state <= S_TRACK;
               end
            end
            S_TERM: begin
               recording <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_song_recorder.sv
// Bench for song_recorder: per-cycle reference model, a take table, and hand-written corner sequences.
module tb_song_recorder;

   localparam int NOTE_AW = 7;
   localparam int MAX_DUR = 63;
   localparam int LAST    = (1 << NOTE_AW) - 1;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                record = 1'b0;
   logic                beat = 1'b0;
   logic [1:0]          song = 2'd0;
   logic                key_valid = 1'b0;
   logic [5:0]          key_note = 6'd0;
   logic                wr_en;
   logic [NOTE_AW+1:0]  wr_addr;
   logic [15:0]         wr_data;
   logic                recording;
   logic                song_full;
   logic                rec_done;

   song_recorder #(.NOTE_AW(NOTE_AW), .MAX_DUR(MAX_DUR)) dut (
      .clk(clk), .reset(reset), .record(record), .beat(beat), .song(song),
      .key_valid(key_valid), .key_note(key_note), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .recording(recording), .song_full(song_full), .rec_done(rec_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int got_q[$];   // {addr, data} of every observed write

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int mk(input int n, input int d);
      return (n << 9) | (d << 3);
   endfunction

   // Reference model: spec phase during the current cycle (0 idle, 1 track, 2 commit, 3 term)
   int m_phase = 0, m_slot = 0, m_idx = 0, m_note = 0, m_dur = 0;
   bit m_full = 0, m_prev = 0;

   function automatic bit counting();
`ifdef REC_TRIM_LEAD_EN
      return !(m_idx == 0 && m_note == 0);
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_step();
      int cur;
      int ex_addr, ex_data;
      if (reset) begin
         chk("rst_wr_en", wr_en, 0);
         chk("rst_recording", recording, 0);
         chk("rst_rec_done", rec_done, 0);
         chk("rst_song_full", song_full, 0);
         m_phase = 0; m_idx = 0; m_full = 0; m_prev = 0; m_note = 0; m_dur = 0; m_slot = 0;
         return;
      end
      ex_addr = (m_slot << NOTE_AW) | m_idx;
      ex_data = (m_phase == 3) ? 'h8000 : mk(m_note, m_dur);
      chk("wr_en", wr_en, int'(m_phase == 2 || m_phase == 3));
      if (m_phase == 2 || m_phase == 3) begin
         chk("wr_addr", wr_addr, ex_addr);
         chk("wr_data", wr_data, ex_data);
      end
      chk("recording", recording, int'(m_phase != 0));
      chk("rec_done", rec_done, int'(m_phase == 3));
      chk("song_full", song_full, int'(m_full));
      // advance using this cycle's inputs
      cur = key_valid ? int'(key_note) : 0;
      case (m_phase)
         0: if (record && !m_prev) begin
            m_slot = song; m_idx = 0; m_note = cur; m_dur = 0; m_full = 0; m_phase = 1;
         end
         1: begin
            if (beat && counting()) m_dur++;
            if (!record) m_phase = (m_dur > 0) ? 2 : 3;
            else if (cur != m_note) begin
               if (m_dur == 0) m_note = cur;
               else m_phase = 2;
            end else if (m_dur == MAX_DUR) m_phase = 2;
         end
         2: begin
            m_idx++; m_note = cur; m_dur = 0;
            if (m_idx == LAST) begin m_full = 1; m_phase = 3; end
            else if (!record) m_phase = 3;
            else m_phase = 1;
         end
         default: m_phase = 0;
      endcase
      m_prev = record;
   endtask

   always @(negedge clk) begin
      if (wr_en) got_q.push_back((int'(wr_addr) << 16) | int'(wr_data));
      model_step();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_key(input int n);
      key_valid = (n != 0);
      key_note  = (n != 0) ? 6'(n) : 6'($urandom);
   endtask

   task automatic do_beats(input int b);
      repeat (b) begin
         beat = 1'b1; tick();
         beat = 1'b0; tick(); tick();
      end
   endtask

   typedef struct {
      int slot, n1, b1, n2, b2;
      int nw, w0, w1, w2;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{2, 20, 3, 0, 2, 3, mk(20, 3), mk(0, 2), 'h8000};
      vecs[1] = '{1, 5, 70, 0, 0, 3, mk(5, 63), mk(5, 7), 'h8000};
`ifdef REC_TRIM_LEAD_EN
      vecs[2] = '{0, 0, 4, 9, 1, 2, mk(9, 1), 'h8000, 0};
`else
      vecs[2] = '{0, 0, 4, 9, 1, 3, mk(0, 4), mk(9, 1), 'h8000};
`endif
      vecs[3] = '{3, 33, 1, 34, 1, 3, mk(33, 1), mk(34, 1), 'h8000};
      vecs[4] = '{0, 7, 0, 8, 2, 2, mk(8, 2), 'h8000, 0};

      repeat (3) tick();
      reset = 1'b0;
      tick(); tick();

      // take table
      foreach (vecs[v]) begin
         int exp_w[3];
         exp_w[0] = vecs[v].w0; exp_w[1] = vecs[v].w1; exp_w[2] = vecs[v].w2;
         got_q.delete();
         record = 1'b1; song = 2'(vecs[v].slot); set_key(vecs[v].n1);
         tick();
         song = ~song;   // mid-take slot change must not matter
         do_beats(vecs[v].b1);
         set_key(vecs[v].n2); tick(); tick();
         do_beats(vecs[v].b2);
         record = 1'b0; set_key(0);
         repeat (6) tick();
         chk($sformatf("tbl%0d_nw", v), got_q.size(), vecs[v].nw);
         for (int i = 0; i < vecs[v].nw && i < got_q.size(); i++) begin
            chk($sformatf("tbl%0d_addr%0d", v, i), got_q[i] >> 16, (vecs[v].slot << NOTE_AW) | i);
            chk($sformatf("tbl%0d_data%0d", v, i), got_q[i] & 'hffff, exp_w[i]);
         end
      end

      // beat and note change in the same cycle, then record-fall latency
      got_q.delete();
      record = 1'b1; song = 2'd1; set_key(10);
      tick();
      do_beats(1);
      beat = 1'b1; set_key(11); tick();
      beat = 1'b0;
      @(negedge clk);
      chk("same_cyc_wr_en", wr_en, 1);
      chk("same_cyc_data", wr_data, mk(10, 2));
      tick(); tick();
      do_beats(1);
      record = 1'b0; set_key(0); tick();
      @(negedge clk);
      chk("fall_data_wr", wr_en, 1);
      chk("fall_data", wr_data, mk(11, 1));
      chk("fall_data_done", rec_done, 0);
      tick();
      @(negedge clk);
      chk("fall_end_data", wr_data, 'h8000);
      chk("fall_end_done", rec_done, 1);
      chk("fall_end_rec", recording, 1);
      tick();
      @(negedge clk);
      chk("fall_after_rec", recording, 0);
      chk("fall_after_wr", wr_en, 0);
      tick(); tick();

      // capacity: alternating one-beat notes until the slot fills
      got_q.delete();
      record = 1'b1; song = 2'd1; set_key(1);
      tick();
      for (int s = 0; s < 132; s++) begin
         beat = 1'b1; tick();
         beat = 1'b0; set_key((s % 2 == 0) ? 2 : 1); tick(); tick();
      end
      chk("full_nw", got_q.size(), LAST + 1);
      if (got_q.size() == LAST + 1) begin
         chk("full_last_addr", got_q[LAST] >> 16, (1 << NOTE_AW) | LAST);
         chk("full_last_data", got_q[LAST] & 'hffff, 'h8000);
         chk("full_126_data", got_q[LAST-1] & 'hffff, mk(1, 1));
      end
      @(negedge clk);
      chk("full_flag", song_full, 1);
      chk("full_rec", recording, 0);
      tick();
      record = 1'b0; tick(); tick();

      // reset two cycles after a commit
      got_q.delete();
      record = 1'b1; song = 2'd0; set_key(3);
      tick();
      do_beats(1);
      set_key(4); tick();   // change seen here, commit on the bus next cycle
      tick(); tick();
      reset = 1'b1;
      #2;
      chk("rst_mid_wr_en", wr_en, 0);
      chk("rst_mid_recording", recording, 0);
      chk("rst_mid_rec_done", rec_done, 0);
      record = 1'b0;
      tick(); tick();
      reset = 1'b0;
      repeat (5) tick();
      chk("rst_mid_writes", got_q.size(), 1);

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         tick();
         beat = ($urandom % 3) == 0;
         if ($urandom % 5 == 0) begin
            key_valid = ($urandom % 4) != 0;
            key_note  = 6'($urandom % 4);
         end
         if ($urandom % 40 == 0) record = ~record;
         song = 2'($urandom);
      end
      record = 1'b0;
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/song_recorder.md
# song_recorder

Writer side of the song memory: captures live key input, quantised to the `beat` tick, into 16-bit song words in the same format `song_reader` consumes. Words are written into a dual-port song RAM slot selected by `song`. Sits between the keypad/switch front end and the song RAM's write port, so a recorded song plays back unchanged through the existing reader path.

## Interface
Parameters:
- `NOTE_AW`, default 7: per-song index width. 2^NOTE_AW words per song; the last index is reserved for the end marker.
- `MAX_DUR`, default 63: segment duration at which a held note is split into a new word.

Ports:
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `record`  input  1  level; rising edge starts a take, falling edge ends it.
- `beat`  input  1  one-cycle tick per duration unit.
- `song`  input  2  target song slot; latched at take start.
- `key_valid`  input  1  a key is held.
- `key_note`  input  6  note code of the held key; ignored when `key_valid`=0.
- `wr_en`  output  1  one-cycle RAM write strobe.
- `wr_addr`  output  2+NOTE_AW  {latched song, index}.
- `wr_data`  output  16  song word.
- `recording`  output  1  take in progress.
- `song_full`  output  1  last take stopped on capacity.
- `rec_done`  output  1  one-cycle pulse when the end marker is written.

## Operation
- Word format:
  - bit15 = end marker;
  - [14:9] = note (0 = rest);
  - [8:3] = duration in beats;
  - [2:0] = 0.
  - The end-marker word is 16'h8000.
- Effective input: `cur_in = key_valid ? key_note : 6'd0`.
- **IDLE**: all strobes low.
  - On `record` rising edge: latch `song`, set idx=0, seg_note=`cur_in`, dur=0, clear `song_full`, go TRACK.
- **TRACK** (`recording`=1):
  - `beat`: dur = dur+1.
  - `cur_in` != seg_note with dur=0: seg_note is replaced; no word is written (zero-length segments are never stored).
  - `cur_in` != seg_note with dur>0: go COMMIT.
  - dur reaches MAX_DUR on a beat: go COMMIT; the next segment keeps the same note.
  - `record` low: go COMMIT if dur>0, else go TERM.
- **COMMIT**: write {1'b0, seg_note, dur, 3'b0} at idx, then idx++, seg_note=`cur_in`, dur=0.
  - If the new idx equals 2^NOTE_AW-1: set `song_full`, go TERM.
  - Else if `record` is low: go TERM.
  - Else: go TRACK.
- **TERM**: write 16'h8000 at idx, pulse `rec_done`, go IDLE.
- Simultaneous `beat` and note change in the same cycle: the beat counts toward the old segment, which is then committed.
- `song` changes mid-take are ignored.
- A `record` rising edge while not in IDLE is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; idx=0.
  - Reset mid-take aborts immediately with no further writes. The RAM keeps any partial take, possibly without an end marker.
- `wr_en`, `wr_addr`, `wr_data` are registered and valid in the same cycle.
- Latency:
  - Note change detected in cycle N: data word written in N+1.
  - `record` falling in cycle N with dur>0: data word written in N+1, end marker in N+2. With dur=0: end marker in N+1.
  - `rec_done` is coincident with the end-marker `wr_en`. `recording` drops the cycle after.
- At most one write per cycle, with strictly increasing idx; no wrap-around.
- dur saturates by construction and never exceeds MAX_DUR.

## Configuration
- `REC_TRIM_LEAD_EN`:
  - Defined: while idx=0, seg_note=0 and no word has yet been written, beats are not counted, so leading silence is discarded. The first word is the first real note.
  - Undefined: leading rests are recorded as note-0 words like any other segment.

## Test plan
- Record song 2, hold note 6'd20 for 3 beats, release, idle 2 beats, drop `record` -> writes:
  - addr 9'h100 = {0,20,3,000};
  - addr 9'h101 = {0,0,2,000};
  - addr 9'h102 = 16'h8000, with `rec_done`.
- Hold note 6'd5 for 70 beats -> two words, {0,5,63} then {0,5,7}, then the end marker.
- Note change in the same cycle as `beat` -> the old note's duration includes that beat; the new segment starts at dur=0.
- 127 alternating notes of 1 beat each -> idx 0..126 written, end marker at idx 127, `song_full`=1; later input is ignored.
- Assert `reset` two cycles after a commit -> `wr_en`, `recording`, `rec_done` all 0 from the reset cycle; no further writes.
- 4 beats of silence then note 9 for 1 beat, `REC_TRIM_LEAD_EN` defined -> first word {0,9,1}. Undefined -> first word {0,0,4}.
